// File: rtl/rtc_clock_core_pkg.sv
// Shared limits and default widths for the real-time clock core.
package rtc_clock_core_pkg;

    localparam int unsigned SecLimit  = 60;
    localparam int unsigned MinLimit  = 60;
    localparam int unsigned HourLimit = 24;
    localparam int unsigned HalfDay   = 12;

    localparam int unsigned DefCountBit = 30;
    localparam int unsigned DefSecBit   = 6;
    localparam int unsigned DefMinBit   = 6;
    localparam int unsigned DefHourBit  = 5;
    localparam int unsigned DefDayBit   = 16;

endpackage

// File: rtl/rtc_clock_core_one_sec_tick_gen.sv
// Programmable divider producing a one-cycle tick every freq enabled clocks.
module one_sec_tick_gen #(
    parameter int unsigned P_COUNT_BIT = 30
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run_en,
    input  logic                   clear,
    input  logic [P_COUNT_BIT-1:0] freq,
    output logic                   tick
);

    logic [P_COUNT_BIT-1:0] cnt_q, cnt_d;
    logic                   wrap;

    // >= so that lowering freq below the current count wraps on the next cycle
    always_comb begin
        wrap  = cnt_q >= (freq - P_COUNT_BIT'(1));
        tick  = run_en & ~clear & wrap;
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run_en) begin
            cnt_d = wrap ? '0 : cnt_q + P_COUNT_BIT'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rtc_clock_core.sv
// Time-of-day core: sec/min/hour/day with ripple carry, load port, 12 h display and alarm.
module rtc_clock_core
    import rtc_clock_core_pkg::*;
#(
    parameter int unsigned P_COUNT_BIT = DefCountBit,
    parameter int unsigned P_SEC_BIT   = DefSecBit,
    parameter int unsigned P_MIN_BIT   = DefMinBit,
    parameter int unsigned P_HOUR_BIT  = DefHourBit,
    parameter int unsigned P_DAY_BIT   = DefDayBit
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_run_en,
    input  logic [P_COUNT_BIT-1:0] i_freq,
    input  logic                   i_load_valid,
    output logic                   o_load_ready,
    input  logic [P_SEC_BIT-1:0]   i_load_sec,
    input  logic [P_MIN_BIT-1:0]   i_load_min,
    input  logic [P_HOUR_BIT-1:0]  i_load_hour,
    output logic                   o_load_err,
    input  logic                   i_mode_12h,
    input  logic                   i_alarm_en,
    input  logic [P_MIN_BIT-1:0]   i_alarm_min,
    input  logic [P_HOUR_BIT-1:0]  i_alarm_hour,
    input  logic                   i_alarm_clr,
    output logic [P_SEC_BIT-1:0]   sec,
    output logic [P_MIN_BIT-1:0]   min,
    output logic [P_HOUR_BIT-1:0]  hour,
    output logic [P_DAY_BIT-1:0]   day,
    output logic [P_HOUR_BIT-1:0]  o_hour_disp,
    output logic                   o_pm,
    output logic                   o_sec_tick,
    output logic                   o_day_tick,
    output logic                   o_alarm
);

    localparam logic [P_SEC_BIT-1:0]  SecMax   = P_SEC_BIT'(SecLimit - 1);
    localparam logic [P_MIN_BIT-1:0]  MinMax   = P_MIN_BIT'(MinLimit - 1);
    localparam logic [P_HOUR_BIT-1:0] HourMax  = P_HOUR_BIT'(HourLimit - 1);
    localparam logic [P_HOUR_BIT-1:0] HourHalf = P_HOUR_BIT'(HalfDay);

    logic [P_SEC_BIT-1:0]  sec_q, sec_d;
    logic [P_MIN_BIT-1:0]  min_q, min_d;
    logic [P_HOUR_BIT-1:0] hour_q, hour_d;
    logic [P_DAY_BIT-1:0]  day_q, day_d;
    logic ready_q, err_q, sec_tick_q, day_tick_q, alarm_q, alarm_d;
    logic tick, load_fire, load_ok, load_take, day_wrap, alarm_set;

    assign load_fire = i_load_valid & ready_q;
    assign load_ok   = (i_load_sec <= SecMax) & (i_load_min <= MinMax) & (i_load_hour <= HourMax);
    assign load_take = load_fire & load_ok;

    // An accepted load realigns the second boundary and suppresses a coincident tick;
    // a rejected load leaves the divider and time alone.
    one_sec_tick_gen #(
        .P_COUNT_BIT(P_COUNT_BIT)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .run_en(i_run_en),
        .clear (load_take),
        .freq  (i_freq),
        .tick  (tick)
    );

    always_comb begin
        sec_d    = sec_q;
        min_d    = min_q;
        hour_d   = hour_q;
        day_d    = day_q;
        day_wrap = 1'b0;
        if (load_take) begin
            sec_d  = i_load_sec;
            min_d  = i_load_min;
            hour_d = i_load_hour;
        end else if (tick) begin
            if (sec_q == SecMax) begin
                sec_d = '0;
                if (min_q == MinMax) begin
                    min_d = '0;
                    if (hour_q == HourMax) begin
                        hour_d   = '0;
                        day_d    = day_q + P_DAY_BIT'(1);
                        day_wrap = 1'b1;
                    end else begin
                        hour_d = hour_q + P_HOUR_BIT'(1);
                    end
                end else begin
                    min_d = min_q + P_MIN_BIT'(1);
                end
            end else begin
                sec_d = sec_q + P_SEC_BIT'(1);
            end
        end
    end

    always_comb begin
        alarm_set = tick & ~load_take & i_alarm_en & (hour_d == i_alarm_hour) &
                    (min_d == i_alarm_min) & (sec_d == '0);
        alarm_d   = alarm_q;
        if (alarm_set) begin
            alarm_d = 1'b1;
        end else if (i_alarm_clr) begin
            alarm_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            day_q      <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            day_q      <= day_d;
            ready_q    <= ~load_fire;
            err_q      <= load_fire & ~load_ok;
            sec_tick_q <= tick & ~load_take;
            day_tick_q <= day_wrap;
            alarm_q    <= alarm_d;
        end
    end

    always_comb begin
        o_pm        = hour_q >= HourHalf;
        o_hour_disp = hour_q;
        if (i_mode_12h) begin
            if (hour_q == '0) begin
                o_hour_disp = HourHalf;
            end else if (hour_q > HourHalf) begin
                o_hour_disp = hour_q - HourHalf;
            end
        end
    end

    assign sec          = sec_q;
    assign min          = min_q;
    assign hour         = hour_q;
    assign day          = day_q;
    assign o_load_ready = ready_q;
    assign o_load_err   = err_q;
    assign o_sec_tick   = sec_tick_q;
    assign o_day_tick   = day_tick_q;
    assign o_alarm      = alarm_q;

endmodule

// File: doc/rtc_clock_core.md
# rtc_clock_core

Parametrised successor time-of-day core: generates a one-second tick from a programmable clock count and keeps sec/min/hour with true ripple carry. It adds a day counter, a handshaked time-load port, 12/24-hour display output and a sticky minute alarm. It sits between the system clock domain and display/host logic as a self-contained real-time clock.

## Interface
- P_COUNT_BIT, 30, tick divider width (i_freq range)
- P_SEC_BIT, 6, seconds width
- P_MIN_BIT, 6, minutes width
- P_HOUR_BIT, 5, hours width
- P_DAY_BIT, 16, day counter width
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- i_run_en  in  1  tick generator enable; 0 freezes time
- i_freq  in  P_COUNT_BIT  clk cycles per second (≥2)
- i_load_valid  in  1  load request
- o_load_ready  out  1  load accept; valid&ready = transfer
- i_load_sec / i_load_min / i_load_hour  in  P_SEC_BIT/P_MIN_BIT/P_HOUR_BIT  time to load (24 h)
- o_load_err  out  1  one-cycle pulse: accepted load was out of range, discarded
- i_mode_12h  in  1  display mode select
- i_alarm_en  in  1  alarm compare enable
- i_alarm_min / i_alarm_hour  in  P_MIN_BIT/P_HOUR_BIT  alarm time (24 h)
- i_alarm_clr  in  1  clears o_alarm
- sec / min / hour  out  as params  registered 24 h time
- day  out  P_DAY_BIT  registered day count
- o_hour_disp  out  P_HOUR_BIT  hour in 24 h, or 1–12 in 12 h mode
- o_pm  out  1  hour ≥ 12 (valid in both modes)
- o_sec_tick  out  1  pulse, cycle time registers change by tick
- o_day_tick  out  1  pulse, cycle 23:59:59→00:00:00 is registered
- o_alarm  out  1  sticky alarm flag

## Operation
- Reset: sec=min=hour=0, day=0, o_alarm=0, o_load_ready=0, all pulses 0; tick counter 0. o_load_ready rises the cycle after reset deasserts.
- Tick: internal counter counts 0..i_freq-1 while i_run_en; one-cycle tick at wrap. i_run_en=0 holds counter value (no clear).
- On tick: sec+1; sec==59 → sec=0, min+1; min==59 too → min=0, hour+1; hour==23 too → hour=0, day+1 (day wraps 2^P_DAY_BIT−1→0), o_day_tick.
- Load: transfer on i_load_valid & o_load_ready. o_load_ready drops for exactly one cycle after each transfer. In range (sec≤59, min≤59, hour≤23): sec/min/hour replaced, day unchanged, tick counter cleared to 0. Out of range: time untouched, o_load_err pulses.
- Load and tick in same cycle: load wins, tick dropped, no o_sec_tick.
- Alarm: set when a tick-driven update produces hour==i_alarm_hour, min==i_alarm_min, sec==0 with i_alarm_en=1. Loads never set alarm. i_alarm_clr clears; set and clear same cycle → set wins.
- 12 h display: hour 0→12 (o_pm=0), 1–11 unchanged, 12→12 (o_pm=1), 13–23→hour−12. i_mode_12h=0: o_hour_disp=hour. o_hour_disp/o_pm combinational from registered hour.

## Timing
- Tick generated in cycle N → sec/min/hour/day, o_sec_tick, o_day_tick, o_alarm visible cycle N+1.
- Load transfer in cycle N → new time or o_load_err visible N+1; o_load_ready=0 in N+1, 1 in N+2.
- After accepted load, first tick occurs exactly i_freq cycles after transfer cycle (with i_run_en=1).
- i_freq change takes effect at next counter wrap compare; counter ≥ new i_freq wraps next cycle.
- Reset mid-operation overrides everything in that cycle, including a pending load.

## Structure
- Shared package/header: second/minute/hour limits (60, 60, 24), 12 h offset, default widths.
- One sub-module: one_sec_tick_gen (counter, run enable, clear input for load realignment, tick pulse).
- Time/day/alarm/load logic in rtc_clock_core itself.

## Test plan
- Reset, i_freq=4, run: sec increments every 4 cycles; o_sec_tick one cycle each; 240 cycles → min=1, sec=0.
- Load 23:59:58, run 8 cycles at i_freq=4 → 00:00:00, day 0→1, o_day_tick one pulse; i_mode_12h=1 → o_hour_disp=12, o_pm=0.
- Load hour=24 → o_load_err pulse, time unchanged, o_load_ready low one cycle then high.
- Alarm 07:30, load 07:29:59, run → o_alarm=1 after one tick, stays 1; i_alarm_clr with simultaneous matching tick → stays 1; clear alone → 0.
- Load asserted in tick cycle → loaded value wins, no o_sec_tick; next tick 4 cycles later.
- i_run_en=0 for 10 cycles mid-second → time frozen, counter resumes from held value; reset mid-run → all outputs 0 next cycle.
